// File: rtl/data_mem_port_arbiter.sv
// data_mem_port_arbiter: shares RAM port A between the CPU memory stage and a burst DMA loader
// Ports:
//   clk, reset (async, active-low)
//   cpu_req/cpu_we/cpu_addr/cpu_wdata -> cpu_ack/cpu_rdata/cpu_stall : pipeline memory stage
//   dma_start/dma_we/dma_base/dma_len  -> dma_busy/dma_done          : burst control
//   dma_wvalid/dma_wdata -> dma_wready ; dma_rvalid/dma_rdata         : burst data beats
//   ram_address/ram_data/ram_wren, ram_q                              : RAM port A (1-cycle read latency)
module data_mem_port_arbiter #(
  parameter int ADDR_W    = 16,
  parameter int DATA_W    = 8,
  parameter int BURST_MAX = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ack,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_stall,
  input  logic              dma_start,
  input  logic              dma_we,
  input  logic [ADDR_W-1:0] dma_base,
  input  logic [4:0]        dma_len,
  input  logic              dma_wvalid,
  input  logic [DATA_W-1:0] dma_wdata,
  output logic              dma_wready,
  output logic              dma_rvalid,
  output logic [DATA_W-1:0] dma_rdata,
  output logic              dma_busy,
  output logic              dma_done,
  output logic [ADDR_W-1:0] ram_address,
  output logic [DATA_W-1:0] ram_data,
  output logic              ram_wren,
  input  logic [DATA_W-1:0] ram_q
);
  typedef enum logic [1:0] {IDLE, CPU_ACC, DMA_XFER, DMA_DRAIN} state_t;
  state_t state, state_nx;
  logic              last_dma;
  logic              dma_pending;
  logic              dma_we_r;
  logic              rvalid_r;
  logic              done_r;
  logic [ADDR_W-1:0] addr;
  logic [4:0]        count;
  logic [4:0]        len_clamped;
  logic              start_ok;
  logic              cpu_gnt;
  logic              dma_gnt;
  logic              beat;
  assign len_clamped = (dma_len > 5'(BURST_MAX)) ? 5'(BURST_MAX) : dma_len;
  assign start_ok    = dma_start & ~dma_busy;
  // Round-robin on a tie: the requester that did not win last time goes first.
  assign cpu_gnt     = reset & (state == IDLE) & cpu_req & (~dma_pending | last_dma);
  assign dma_gnt     = reset & (state == IDLE) & dma_pending & (~cpu_req | ~last_dma);
  // Read bursts issue every cycle; write bursts only when the loader has data.
  assign beat        = (state == DMA_XFER) & (~dma_we_r | dma_wvalid);
  assign cpu_ack     = (state == CPU_ACC);
  assign cpu_rdata   = cpu_ack ? ram_q : '0;
  assign cpu_stall   = cpu_req & ~cpu_ack;
  assign dma_wready  = (state == DMA_XFER) & dma_we_r;
  assign dma_rvalid  = rvalid_r;
  assign dma_rdata   = rvalid_r ? ram_q : '0;
  assign dma_done    = done_r | (state == DMA_DRAIN);
  // The drain cycle carries dma_done, so busy already reads low there.
  assign dma_busy    = dma_pending | (state == DMA_XFER);
  always_ff @(posedge clk or negedge reset)
    if (!reset) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx    = state;
    ram_address = '0;
    ram_data    = '0;
    ram_wren    = 1'b0;
    case (state)
      IDLE: begin
        state_nx    = cpu_gnt ? CPU_ACC : dma_gnt ? DMA_XFER : IDLE;
        ram_address = cpu_gnt ? cpu_addr : '0;
        ram_data    = cpu_gnt ? cpu_wdata : '0;
        ram_wren    = cpu_gnt & cpu_we;
      end
      CPU_ACC: state_nx = IDLE;
      DMA_XFER: begin
        state_nx    = (beat && count == 5'd1) ? (dma_we_r ? IDLE : DMA_DRAIN) : DMA_XFER;
        ram_address = addr;
        ram_data    = dma_we_r ? dma_wdata : '0;
        ram_wren    = beat & dma_we_r;
      end
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      last_dma    <= 1'b1;
      dma_pending <= 1'b0;
      dma_we_r    <= 1'b0;
      rvalid_r    <= 1'b0;
      done_r      <= 1'b0;
      addr        <= '0;
      count       <= '0;
    end else begin
      done_r   <= (start_ok & (len_clamped == 5'd0)) | (beat & dma_we_r & (count == 5'd1));
      rvalid_r <= beat & ~dma_we_r;
      if (cpu_gnt) last_dma <= 1'b0;
      else if (dma_gnt) last_dma <= 1'b1;
      if (dma_gnt) dma_pending <= 1'b0;
      // Burst parameters are loaded at acceptance; busy blocks reloads until the burst ends.
      if (start_ok && len_clamped != 5'd0) begin
        dma_pending <= 1'b1;
        dma_we_r    <= dma_we;
        addr        <= dma_base;
        count       <= len_clamped;
      end
      if (beat) begin
        addr  <= addr + ADDR_W'(1);
        count <= count - 5'd1;
      end
    end
endmodule

// File: tb/tb_data_mem_port_arbiter.sv
// tb_data_mem_port_arbiter: directed self-checking bench for data_mem_port_arbiter
module tb_data_mem_port_arbiter;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        cpu_req = 1'b0, cpu_we = 1'b0;
  logic [15:0] cpu_addr = '0;
  logic [7:0]  cpu_wdata = '0;
  logic        cpu_ack, cpu_stall;
  logic [7:0]  cpu_rdata;
  logic        dma_start = 1'b0, dma_we = 1'b0;
  logic [15:0] dma_base = '0;
  logic [4:0]  dma_len = '0;
  logic        dma_wvalid = 1'b0;
  logic [7:0]  dma_wdata = '0;
  logic        dma_wready, dma_rvalid, dma_busy, dma_done;
  logic [7:0]  dma_rdata;
  logic [15:0] ram_address;
  logic [7:0]  ram_data;
  logic        ram_wren;
  logic [7:0]  ram_q = '0;
  logic [7:0]  mem [0:65535];
  int          checks = 0;
  int          errors = 0;
  data_mem_port_arbiter dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
    .dma_start(dma_start), .dma_we(dma_we), .dma_base(dma_base), .dma_len(dma_len),
    .dma_wvalid(dma_wvalid), .dma_wdata(dma_wdata), .dma_wready(dma_wready),
    .dma_rvalid(dma_rvalid), .dma_rdata(dma_rdata), .dma_busy(dma_busy), .dma_done(dma_done),
    .ram_address(ram_address), .ram_data(ram_data), .ram_wren(ram_wren), .ram_q(ram_q)
  );
  always #5 clk = ~clk;
  always_ff @(posedge clk) begin
    if (ram_wren) mem[ram_address] <= ram_data;
    ram_q <= mem[ram_address];
  end
  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask
  task automatic nxt;
    @(posedge clk);
    #1;
  endtask
  task automatic smp;
    @(negedge clk);
  endtask
  task automatic cpu_op(input logic we, input logic [15:0] a, input logic [7:0] wd, input logic [7:0] exp_rd);
    nxt; cpu_req = 1'b1; cpu_we = we; cpu_addr = a; cpu_wdata = wd;
    smp;
    chk("cpu_issue_stall", 32'(cpu_stall), 1);
    chk("cpu_issue_ack", 32'(cpu_ack), 0);
    chk("cpu_issue_wren", 32'(ram_wren), 32'(we));
    chk("cpu_issue_addr", 32'(ram_address), 32'(a));
    nxt;
    smp;
    chk("cpu_ack", 32'(cpu_ack), 1);
    chk("cpu_ack_stall", 32'(cpu_stall), 0);
    if (!we) chk("cpu_rdata", 32'(cpu_rdata), 32'(exp_rd));
    nxt; cpu_req = 1'b0;
  endtask
  task automatic dma_wr(input logic [15:0] base, input logic [4:0] len, input int n, input logic [7:0] d0);
    int w = 0;
    nxt; dma_start = 1'b1; dma_we = 1'b1; dma_base = base; dma_len = len;
    nxt; dma_start = 1'b0; dma_wvalid = 1'b1; dma_wdata = d0;
    smp;
    while (!dma_wready && w < 8) begin nxt; smp; w++; end
    chk("wr_grant", 32'(dma_wready), 1);
    for (int i = 0; i < n; i++) begin
      logic [15:0] ea;
      logic [7:0]  ed;
      ea = base + 16'(i);
      ed = d0 + 8'(i);
      chk("wr_wren", 32'(ram_wren), 1);
      chk("wr_addr", 32'(ram_address), 32'(ea));
      chk("wr_data", 32'(ram_data), 32'(ed));
      chk("wr_early_done", 32'(dma_done), 0);
      nxt; dma_wdata = ed + 8'd1;
      smp;
    end
    chk("wr_done", 32'(dma_done), 1);
    chk("wr_busy_at_done", 32'(dma_busy), 0);
    chk("wr_no_extra_beat", 32'({dma_wready, ram_wren}), 0);
    dma_wvalid = 1'b0;
  endtask
  task automatic dma_rd(input logic [15:0] base, input logic [4:0] len, input int n, input logic [7:0] d0);
    int w = 0;
    nxt; dma_start = 1'b1; dma_we = 1'b0; dma_base = base; dma_len = len;
    nxt; dma_start = 1'b0;
    smp;
    while (!dma_rvalid && w < 8) begin nxt; smp; w++; end
    for (int i = 0; i < n; i++) begin
      logic [7:0] ed;
      ed = d0 + 8'(i);
      chk("rd_valid", 32'(dma_rvalid), 1);
      chk("rd_data", 32'(dma_rdata), 32'(ed));
      chk("rd_done", 32'(dma_done), 32'(i == n - 1));
      chk("rd_busy", 32'(dma_busy), 32'(i != n - 1));
      nxt;
      smp;
    end
    chk("rd_idle", 32'({dma_rvalid, dma_done, dma_busy}), 0);
  endtask
  initial begin
    int  w, nrv, done_at, ack_at;
    logic stall_ok, rd_ok, done_seen;
    // reset state
    nxt; nxt;
    smp;
    chk("rst_ctl", 32'({cpu_ack, cpu_stall, dma_wready, dma_rvalid, dma_busy, dma_done, ram_wren}), 0);
    chk("rst_rdata", 32'({cpu_rdata, dma_rdata}), 0);
    nxt; reset = 1'b1;
    // tie right after reset: CPU first, then DMA on the repeated tie
    nxt; cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h0040; cpu_wdata = 8'h55;
    dma_start = 1'b1; dma_we = 1'b1; dma_base = 16'h0050; dma_len = 5'd1;
    smp;
    chk("tie1_cpu_wren", 32'(ram_wren), 1);
    chk("tie1_cpu_addr", 32'(ram_address), 32'h40);
    chk("tie1_busy", 32'(dma_busy), 0);
    nxt; dma_start = 1'b0; dma_wvalid = 1'b1; dma_wdata = 8'h66;
    smp;
    chk("tie1_ack", 32'(cpu_ack), 1);
    chk("tie1_busy_set", 32'(dma_busy), 1);
    nxt; cpu_addr = 16'h0041; cpu_wdata = 8'h77;
    smp;
    chk("tie2_cpu_waits", 32'({cpu_stall, ram_wren}), 32'b10);
    nxt;
    smp;
    chk("tie2_dma_beat", 32'({dma_wready, ram_wren}), 32'b11);
    chk("tie2_dma_addr", 32'(ram_address), 32'h50);
    chk("tie2_dma_data", 32'(ram_data), 32'h66);
    chk("tie2_stall", 32'(cpu_stall), 1);
    nxt; dma_wvalid = 1'b0;
    smp;
    chk("tie2_done", 32'(dma_done), 1);
    chk("tie3_cpu_addr", 32'(ram_address), 32'h41);
    chk("tie3_cpu_data", 32'({ram_wren, ram_data}), 32'h177);
    nxt;
    smp;
    chk("tie3_ack", 32'(cpu_ack), 1);
    nxt; cpu_req = 1'b0;
    // CPU write then read
    cpu_op(1'b1, 16'h0010, 8'hAB, 8'h00);
    cpu_op(1'b0, 16'h0010, 8'h00, 8'hAB);
    // DMA write 1..4 at 0x20 and read back
    dma_wr(16'h0020, 5'd4, 4, 8'h01);
    dma_rd(16'h0020, 5'd4, 4, 8'h01);
    // address wrap
    dma_wr(16'hFFFE, 5'd3, 3, 8'h90);
    dma_rd(16'hFFFE, 5'd3, 3, 8'h90);
    // length clamp to 16
    dma_wr(16'h0100, 5'd20, 16, 8'hA0);
    // zero-length burst
    nxt; dma_start = 1'b1; dma_we = 1'b1; dma_base = 16'h0300; dma_len = 5'd0;
    smp;
    chk("len0_no_done_yet", 32'(dma_done), 0);
    nxt; dma_start = 1'b0;
    smp;
    chk("len0_done", 32'({dma_done, dma_busy, ram_wren}), 32'b100);
    nxt;
    smp;
    chk("len0_after", 32'({dma_done, dma_busy, ram_wren, dma_wready}), 0);
    // CPU read arriving during a 16-beat read burst
    nxt; dma_start = 1'b1; dma_we = 1'b0; dma_base = 16'h0100; dma_len = 5'd16;
    nxt; dma_start = 1'b0;
    nxt;
    nxt; cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0010;
    stall_ok = 1'b1; rd_ok = 1'b1; nrv = 0; done_at = -1; ack_at = -1;
    for (int c = 3; c < 40 && ack_at < 0; c++) begin
      smp;
      if (dma_rvalid) begin
        if (dma_rdata !== 8'hA0 + 8'(nrv)) rd_ok = 1'b0;
        nrv++;
      end
      if (dma_done) done_at = c;
      if (cpu_ack) begin
        ack_at = c;
        chk("stall_cpu_rdata", 32'(cpu_rdata), 32'hAB);
      end else if (!cpu_stall) stall_ok = 1'b0;
      nxt;
    end
    cpu_req = 1'b0;
    chk("stall_held", 32'(stall_ok), 1);
    chk("stall_rd_beats", 32'(nrv), 16);
    chk("stall_rd_data", 32'(rd_ok), 1);
    chk("stall_done_cycle", 32'(done_at), 18);
    chk("stall_ack_cycle", 32'(ack_at), 20);
    // reset during beat 2 of a write burst
    nxt; dma_start = 1'b1; dma_we = 1'b1; dma_base = 16'h0200; dma_len = 5'd4;
    nxt; dma_start = 1'b0; dma_wvalid = 1'b1; dma_wdata = 8'h30;
    smp;
    w = 0;
    while (!dma_wready && w < 8) begin nxt; smp; w++; end
    chk("mid_b1_addr", 32'({ram_wren, ram_address}), 32'h10200);
    nxt; dma_wdata = 8'h31;
    #1 reset = 1'b0;
    #1;
    chk("mid_async_clear", 32'({dma_wready, ram_wren, dma_busy, dma_done}), 0);
    dma_wvalid = 1'b0;
    nxt;
    nxt; reset = 1'b1;
    done_seen = 1'b0;
    for (int i = 0; i < 3; i++) begin
      smp;
      if (dma_done || dma_busy) done_seen = 1'b1;
      nxt;
    end
    chk("mid_no_done", 32'(done_seen), 0);
    dma_wr(16'h0200, 5'd4, 4, 8'h30);
    dma_rd(16'h0200, 5'd4, 4, 8'h30);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
